// File: rtl/data_mem_responder.sv
// Fixed-latency 64-bit data memory responder for a CPU MEM stage: IDLE/BUSY/RESP FSM over an inferred RAM.
// Optional macro DMR_ALIGN_CHECK_EN turns misaligned requests into error responses with no memory effect.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] mem_addr_in,
  input  logic [63:0] write_data,
  output logic [63:0] data_out,
  output logic        resp_valid,
  output logic        mem_stall,
  output logic        align_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         FAST     = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic          wr_q;
  logic          mis_q;
  logic [63:0]   data_out_q;
  logic          resp_valid_q;
  logic          align_err_q;
  logic [63:0]   mem_q [DEPTH_WORDS];

  logic          req;
  logic          mis;
  logic          from_idle;
  logic          enter_resp;
  logic [AW-1:0] idx_in;
  logic [AW-1:0] acc_idx;
  logic [63:0]   acc_data;
  logic          acc_wr;
  logic          acc_mis;
  logic          unused_addr;

  assign req    = mem_read ^ mem_write;
  assign idx_in = mem_addr_in[AW+2:3];

`ifdef DMR_ALIGN_CHECK_EN
  assign mis = |mem_addr_in[2:0];
`else
  assign mis = 1'b0;
`endif

  assign unused_addr = ^{mem_addr_in[63:AW+3], mem_addr_in[2:0]};

  // A single-cycle access completes straight from IDLE, so take operands from the ports then.
  assign from_idle  = (state_q == IDLE);
  assign enter_resp = (from_idle && req && FAST) || ((state_q == BUSY) && (cnt_q == 4'd0));
  assign acc_idx    = from_idle ? idx_in     : idx_q;
  assign acc_data   = from_idle ? write_data : wdata_q;
  assign acc_wr     = from_idle ? mem_write  : wr_q;
  assign acc_mis    = from_idle ? mis        : mis_q;

  assign mem_stall  = (from_idle && req) || (state_q == BUSY);
  assign data_out   = data_out_q;
  assign resp_valid = resp_valid_q;
  assign align_err  = align_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      data_out_q   <= 64'd0;
      resp_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      resp_valid_q <= enter_resp;
      align_err_q  <= enter_resp && acc_mis;
      if (enter_resp && !acc_wr && !acc_mis) begin
        data_out_q <= mem_q[acc_idx];
      end
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (FAST) begin
              state_q <= RESP;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand latch needs no reset: it is only consumed after a fresh acceptance.
  always_ff @(posedge clock) begin
    if (from_idle && req) begin
      idx_q   <= idx_in;
      wdata_q <= write_data;
      wr_q    <= mem_write;
      mis_q   <= mis;
    end
  end

  // Memory is never cleared; reset only blocks a completing store.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp && acc_wr && !acc_mis) begin
      mem_q[acc_idx] <= acc_data;
    end
  end

endmodule
